// File: rtl/soc_mem_arbiter.sv
//------------------------------------------------------------------------------
// soc_mem_arbiter : two-port (instr/data) single-cycle arbiter onto a word SRAM.
// Optional round-robin conflict resolution: define SOC_MEM_ARB_RR_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module soc_mem_arbiter #(
   parameter int WORDS  = 1024,
   parameter int ADDR_W = 22
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              instr_req,
   input  logic [31:0]       instr_addr,
   output logic              instr_gnt,
   output logic              instr_rvalid,
   output logic              instr_err,
   output logic [31:0]       instr_rdata,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [3:0]        data_be,
   input  logic [31:0]       data_addr,
   input  logic [31:0]       data_wdata,
   output logic              data_gnt,
   output logic              data_rvalid,
   output logic              data_err,
   output logic [31:0]       data_rdata,
   output logic              mem_ena,
   output logic [3:0]        mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [29:0] c_words = 30'(WORDS);

   logic        w_gnt_instr;
   logic        w_gnt_data;
   logic        w_any;
   logic [31:0] w_addr;
   logic        w_oor;
   logic        w_we;
   logic        w_unused_lsb;

   // response pipeline stage: one entry, valid exactly one cycle after a grant
   logic        r_valid;
   logic        r_port;
   logic        r_oor;
   logic        r_we;

`ifdef SOC_MEM_ARB_RR_EN
   // 1 = data was granted last, 0 = instr (reset value)
   logic        r_last_data;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_last_data <= 1'b0;
      end else if (w_any) begin
         r_last_data <= w_gnt_data;
      end
   end
`endif

   always_comb begin
      w_gnt_instr = 1'b0;
      w_gnt_data  = 1'b0;
      if (instr_req && data_req) begin
`ifdef SOC_MEM_ARB_RR_EN
         w_gnt_data  = ~r_last_data;
         w_gnt_instr = r_last_data;
`else
         w_gnt_data  = 1'b1;
`endif
      end else begin
         w_gnt_instr = instr_req;
         w_gnt_data  = data_req;
      end
   end

   assign w_any        = w_gnt_instr | w_gnt_data;
   assign w_addr       = w_gnt_data ? data_addr : instr_addr;
   assign w_oor        = (w_addr[31:2] >= c_words);
   assign w_we         = w_gnt_data & data_we;
   assign w_unused_lsb = ^w_addr[1:0];

   assign instr_gnt = w_gnt_instr;
   assign data_gnt  = w_gnt_data;
   assign mem_ena   = w_any & ~w_oor;
   assign mem_wen   = (mem_ena && w_we) ? data_be : 4'b0000;
   assign mem_addr  = w_any ? w_addr[ADDR_W+1:2] : '0;
   assign mem_wdata = mem_ena ? data_wdata : 32'h0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_valid <= 1'b0;
         r_port  <= 1'b0;
         r_oor   <= 1'b0;
         r_we    <= 1'b0;
      end else begin
         r_valid <= w_any;
         r_port  <= w_gnt_data;
         r_oor   <= w_any & w_oor;
         r_we    <= w_we;
      end
   end

   // writes and out-of-range accesses return zero data
   assign instr_rvalid = r_valid & ~r_port;
   assign instr_err    = instr_rvalid & r_oor;
   assign instr_rdata  = (instr_rvalid && !r_oor) ? mem_rdata : 32'h0;

   assign data_rvalid  = r_valid & r_port;
   assign data_err     = data_rvalid & r_oor;
   assign data_rdata   = (data_rvalid && !r_oor && !r_we) ? mem_rdata : 32'h0;

endmodule

`default_nettype wire
